core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 133 +++++++++++++
 tb/tb_core_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/decode/execute/writeback sequencer with trap handling
module core_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_we,
    input  logic        dec_error,
    output logic        exec_en,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    // Counter holds the number of ack-less FETCH cycles already completed,
    // so the last permitted cycle is seen when it equals FETCH_TIMEOUT-1.
    localparam int             CW       = $clog2(FETCH_TIMEOUT);
    localparam logic [CW-1:0]  TMO_LAST = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          we_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        exec_en  = 1'b0;
        rf_we    = 1'b0;
        halt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nx = S_DECODE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = S_TRAP;
                end
            end
            S_DECODE: begin
                state_nx = dec_error ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                exec_en  = 1'b1;
                state_nx = S_WB;
            end
            S_WB: begin
                rf_we    = we_q;
                state_nx = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                halt = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc;

    // Datapath registers: instruction latch, timeout counter, trap cause, pc and retire count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= 32'h0;
            instret    <= 32'h0;
            trap_cause <= 2'b00;
            tmo_cnt    <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr   <= imem_rdata;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        trap_cause <= 2'b10;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_error) begin
                        trap_cause <= 2'b01;
                    end else begin
                        we_q <= dec_we;
                    end
                end
                S_WB: begin
                    pc      <= pc + 32'd4;
                    instret <= instret + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer with a behavioural model
module tb_core_sequencer;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int          TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_we;
    logic        dec_error;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        exec_en;
    logic        rf_we;
    logic [31:0] pc;
    logic        halt;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    core_sequencer #(
        .RESET_PC      (RPC),
        .FETCH_TIMEOUT (TMO)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .dec_we     (dec_we),
        .dec_error  (dec_error),
        .exec_en    (exec_en),
        .rf_we      (rf_we),
        .pc         (pc),
        .halt       (halt),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: an instruction is either being fetched (counting
    // ack-less cycles) or is N cycles past its ack (1 decode, 2 execute, 3 writeback).
    bit          m_valid = 1'b0;
    bit          m_active;
    bit          m_fetching;
    int          m_post;
    int          m_waited;
    bit          m_we;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;
    logic [1:0]  m_cause;

    // Advance the model on every rising edge from the inputs the DUT also sees
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid    = 1'b1;
            m_active   = 1'b0;
            m_fetching = 1'b0;
            m_post     = 0;
            m_waited   = 0;
            m_we       = 1'b0;
            m_pc       = RPC;
            m_instr    = 32'h0;
            m_instret  = 32'h0;
            m_cause    = 2'b00;
        end else if (!m_valid || m_cause != 2'b00) begin
        end else if (!m_active) begin
            if (run) begin
                m_active   = 1'b1;
                m_fetching = 1'b1;
                m_waited   = 0;
            end
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_instr    = imem_rdata;
                m_fetching = 1'b0;
                m_post     = 1;
            end else begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_cause    = 2'b10;
                    m_active   = 1'b0;
                    m_fetching = 1'b0;
                end
            end
        end else if (m_post == 1) begin
            if (dec_error) begin
                m_cause  = 2'b01;
                m_active = 1'b0;
                m_post   = 0;
            end else begin
                m_we   = dec_we;
                m_post = 2;
            end
        end else if (m_post == 2) begin
            m_post = 3;
        end else begin
            m_pc      = m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            m_post    = 0;
            if (run) begin
                m_fetching = 1'b1;
                m_waited   = 0;
            end else begin
                m_active = 1'b0;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("imem_req", 32'(imem_req), 32'(m_active && m_fetching && m_cause == 2'b00));
            check("imem_addr", imem_addr, m_pc);
            check("pc", pc, m_pc);
            check("instr", instr, m_instr);
            check("exec_en", 32'(exec_en), 32'(m_cause == 2'b00 && m_post == 2));
            check("rf_we", 32'(rf_we), 32'(m_cause == 2'b00 && m_post == 3 && m_we));
            check("halt", 32'(halt), 32'(m_cause != 2'b00));
            check("trap_cause", 32'(trap_cause), 32'(m_cause));
            check("instret", instret, m_instret);
        end
    end

    int ack_pct;

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        dec_we     = 1'b0;
        dec_error  = 1'b0;
        @(negedge clk);
        step();
        step();

        // Reset state
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_pc", pc, 32'hFFFF_FFF8);
        check("rst_instret", instret, 32'h0);
        check("rst_instr", instr, 32'h0);

        // Basic flow, ack on first fetch cycle
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        check("basic_req", 32'(imem_req), 32'h1);
        check("basic_addr", imem_addr, 32'hFFFF_FFF8);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        dec_we     = 1'b1;
        step();
        imem_ack = 1'b0;
        check("basic_instr", instr, 32'h0050_0093);
        step();
        check("basic_exec", 32'(exec_en), 32'h1);
        step();
        check("basic_rf_we", 32'(rf_we), 32'h1);
        check("basic_exec_off", 32'(exec_en), 32'h0);
        step();
        check("basic_req_again", 32'(imem_req), 32'h1);
        check("basic_pc", pc, 32'hFFFF_FFFC);
        check("basic_instret", instret, 32'h1);

        // Three wait states, run dropped during execute, pc wraps to zero
        dec_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wait_req", 32'(imem_req), 32'h1);
            check("wait_addr", imem_addr, 32'hFFFF_FFFC);
            imem_ack   = (i == 3);
            imem_rdata = 32'h1234_5678;
            step();
        end
        imem_ack = 1'b0;
        step();
        check("pause_exec", 32'(exec_en), 32'h1);
        run = 1'b0;
        step();
        check("pause_rf_we", 32'(rf_we), 32'h0);
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_instret", instret, 32'h2);
        check("pause_idle", 32'(imem_req), 32'h0);
        step();
        check("pause_idle2", 32'(imem_req), 32'h0);

        // Illegal instruction trap, later acks ignored
        run = 1'b1;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack  = 1'b0;
        dec_error = 1'b1;
        step();
        dec_error = 1'b0;
        check("ill_halt", 32'(halt), 32'h1);
        check("ill_cause", 32'(trap_cause), 32'h1);
        check("ill_pc", pc, 32'h0);
        check("ill_instret", instret, 32'h2);
        for (int i = 0; i < 6; i++) begin
            imem_ack   = i[0];
            imem_rdata = 32'h0BAD_0BAD;
            run        = i[1];
            step();
        end
        imem_ack = 1'b0;
        check("ill_instr_frozen", instr, 32'hDEAD_BEEF);
        check("ill_still_halt", 32'(halt), 32'h1);

        // Reset out of the trap
        rst_n = 1'b0;
        step();
        check("trst_halt", 32'(halt), 32'h0);
        check("trst_cause", 32'(trap_cause), 32'h0);
        check("trst_pc", pc, 32'hFFFF_FFF8);
        check("trst_instret", instret, 32'h0);

        // Fetch timeout after 16 ack-less cycles
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        for (int k = 1; k <= TMO; k++) begin
            check("tmo_req", 32'(imem_req), 32'h1);
            check("tmo_nohalt", 32'(halt), 32'h0);
            step();
        end
        check("tmo_halt", 32'(halt), 32'h1);
        check("tmo_cause", 32'(trap_cause), 32'h2);
        check("tmo_req_off", 32'(imem_req), 32'h0);

        // Ack on the 16th cycle wins over the timeout
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 1; k <= TMO; k++) begin
            imem_ack   = (k == TMO);
            imem_rdata = 32'hCAFE_F00D;
            step();
        end
        imem_ack = 1'b0;
        check("tmo_edge_halt", 32'(halt), 32'h0);
        check("tmo_edge_instr", instr, 32'hCAFE_F00D);

        // Reset mid-fetch with an ack pending
        step();
        step();
        step();
        check("mid_req", 32'(imem_req), 32'h1);
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("mid_req_off", 32'(imem_req), 32'h0);
        check("mid_instr", instr, 32'h0);
        check("mid_pc", pc, 32'hFFFF_FFF8);
        check("mid_instret", instret, 32'h0);
        rst_n = 1'b1;

        // Randomized traffic with varying ack density
        ack_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_pct = 0;
                    1:       ack_pct = 10;
                    2:       ack_pct = 50;
                    default: ack_pct = 90;
                endcase
            end
            rst_n      = ($urandom_range(0, 149) != 0);
            run        = ($urandom_range(0, 7) != 0);
            imem_ack   = ($urandom_range(0, 99) < ack_pct);
            imem_rdata = $urandom;
            dec_we     = $urandom_range(0, 1) == 1;
            dec_error  = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
